// File: rtl/vector_alu_pipe.sv
// Two-stage multi-lane vector ALU: S1 computes and registers each beat, S2 is the output register.
// Cross-beat reductions fold into an accumulator and emit only on the last beat.
//
// state    | meaning
// RED_IDLE | no reduction in progress; next reduction beat seeds from vs1 lane 0
// RED_ACC  | reduction open; further beats fold into the accumulator
module vector_alu_pipe #(
    parameter int LANES = 4,
    parameter int ELEN  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [2:0]              opcode,
    input  logic [2:0]              vsew,
    input  logic                    vm,
    input  logic [LANES-1:0]        mask,
    input  logic                    use_scalar,
    input  logic [31:0]             rs,
    input  logic [LANES*ELEN-1:0]   vs1,
    input  logic [LANES*ELEN-1:0]   vs2,
    input  logic [LANES*ELEN-1:0]   vs3,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ELEN-1:0]   out_result,
    output logic [LANES-1:0]        out_mask,
    output logic                    out_last,
    output logic                    out_err
);
    localparam int W = LANES * ELEN;
    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_MACC   = 3'd2;
    localparam logic [2:0] OP_NMSAC  = 3'd3;
    localparam logic [2:0] OP_MADC   = 3'd4;
    localparam logic [2:0] OP_MSBC   = 3'd5;
    localparam logic [2:0] OP_REDSUM = 3'd6;
    localparam logic [2:0] OP_REDMAX = 3'd7;
    localparam logic [0:0] RED_IDLE  = 1'b0;
    localparam logic [0:0] RED_ACC   = 1'b1;

    logic [0:0]       red_state;
    logic [ELEN-1:0]  acc;
    logic             s1_valid, s1_last, s1_err;
    logic [W-1:0]     s1_result;
    logic [LANES-1:0] s1_mask;
    logic             advance, sew_ok, is_red, err_beat;
    logic [ELEN-1:0]  sew_mask, rs_ext, red_fold;
    logic [ELEN+31:0] rs_wide;
    logic [W-1:0]     elem_result;
    logic [LANES-1:0] elem_mask;

    // Sign-extend from the top bit selected by the SEW mask.
    function automatic logic [ELEN-1:0] sext(input logic [ELEN-1:0] x, input logic [ELEN-1:0] m);
        return (x & m) | (((x & m & ~(m >> 1)) != '0) ? ~m : '0);
    endfunction

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign rs_wide  = {{ELEN{rs[31]}}, rs};
    assign rs_ext   = rs_wide[ELEN-1:0];
    assign is_red   = (opcode == OP_REDSUM) || (opcode == OP_REDMAX);
    assign err_beat = !sew_ok || ((red_state == RED_ACC) && !is_red);

    always_comb begin
        sew_ok = (vsew <= 3'd3) && ((8 << vsew[1:0]) <= ELEN);
        if ((8 << vsew[1:0]) >= ELEN) sew_mask = '1;
        else                          sew_mask = (ELEN'(1) << (8 << vsew[1:0])) - ELEN'(1);
    end

    always_comb begin
        logic [ELEN-1:0] a, b, c, r;
        logic [ELEN:0]   sum;
        logic            cb, active;
        a = '0; b = '0; c = '0; r = '0; sum = '0; cb = 1'b0; active = 1'b0;
        elem_result = '0;
        elem_mask   = '0;
        red_fold    = (red_state == RED_IDLE) ? ((use_scalar ? rs_ext : vs1[ELEN-1:0]) & sew_mask) : acc;
        for (int i = 0; i < LANES; i++) begin
            a      = use_scalar ? rs_ext : vs1[i*ELEN +: ELEN];
            b      = vs2[i*ELEN +: ELEN];
            c      = vs3[i*ELEN +: ELEN];
            active = vm || mask[i];
            cb     = 1'b0;
            sum    = {1'b0, b & sew_mask} + {1'b0, a & sew_mask};
            case (opcode)
                OP_ADD:   r = b + a;
                OP_SUB:   r = b - a;
                OP_MACC:  r = a * b + c;
                OP_NMSAC: r = c - a * b;
                OP_MADC: begin
                    cb = |(sum & ({1'b0, sew_mask} + (ELEN+1)'(1)));
                    r  = ELEN'(cb);
                end
                OP_MSBC: begin
                    cb = (b & sew_mask) < (a & sew_mask);
                    r  = ELEN'(cb);
                end
                default:  r = '0;
            endcase
            if (!active) begin
                r  = c;
                cb = 1'b0;
            end
            elem_result[i*ELEN +: ELEN] = r & sew_mask;
            elem_mask[i]                = cb;
            if (active && opcode == OP_REDSUM)
                red_fold = (red_fold + b) & sew_mask;
            else if (active && opcode == OP_REDMAX && $signed(sext(b, sew_mask)) > $signed(sext(red_fold, sew_mask)))
                red_fold = b & sew_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            red_state  <= RED_IDLE;
            acc        <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_err     <= 1'b0;
            s1_result  <= '0;
            s1_mask    <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_mask   <= '0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
        end else if (advance) begin
            out_valid  <= s1_valid;
            out_result <= s1_result;
            out_mask   <= s1_mask;
            out_last   <= s1_last;
            out_err    <= s1_err;
            s1_valid   <= 1'b0;
            if (in_valid) begin
                s1_last <= in_last;
                if (err_beat) begin
                    s1_valid  <= 1'b1;
                    s1_result <= '0;
                    s1_mask   <= '0;
                    s1_err    <= 1'b1;
                    red_state <= RED_IDLE;
                    acc       <= '0;
                end else if (is_red) begin
                    s1_mask <= '0;
                    s1_err  <= 1'b0;
                    // Non-last reduction beats leave a bubble in S1.
                    if (in_last) begin
                        s1_valid  <= 1'b1;
                        s1_result <= W'(red_fold);
                        red_state <= RED_IDLE;
                        acc       <= '0;
                    end else begin
                        acc       <= red_fold;
                        red_state <= RED_ACC;
                    end
                end else begin
                    s1_valid  <= 1'b1;
                    s1_result <= elem_result;
                    s1_mask   <= elem_mask;
                    s1_err    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_vector_alu_pipe.sv
// Bench for vector_alu_pipe: directed cases plus randomized beats checked against a
// queue-based arithmetic reference model; a negedge monitor scores every output beat.
module tb_vector_alu_pipe;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_last = 1'b0;
    logic [2:0]   opcode = '0;
    logic [2:0]   vsew = '0;
    logic         vm = 1'b1;
    logic [3:0]   mask = '0;
    logic         use_scalar = 1'b0;
    logic [31:0]  rs = '0;
    logic [255:0] vs1 = '0, vs2 = '0, vs3 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [255:0] out_result;
    logic [3:0]   out_mask;
    logic         out_last;
    logic         out_err;

    vector_alu_pipe #(.LANES(4), .ELEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .opcode(opcode), .vsew(vsew), .vm(vm), .mask(mask), .use_scalar(use_scalar), .rs(rs),
        .vs1(vs1), .vs2(vs2), .vs3(vs3), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_mask(out_mask), .out_last(out_last), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op; logic [2:0] vsew; logic vm; logic [3:0] mask; logic us; logic [31:0] rs;
        logic [255:0] v1; logic [255:0] v2; logic [255:0] v3; logic last;
    } beat_t;
    typedef struct { logic [255:0] res; logic [3:0] m; logic last; logic err; } exp_t;

    exp_t exp_q[$];
    int   total = 0, passed = 0;
    bit   m_red = 0;
    longint unsigned m_acc = 0;
    logic [255:0] last_res;
    logic [3:0]   last_mask;
    logic         last_last;
    int           out_count = 0;
    bit           stall_prev = 0;
    logic [261:0] stall_snap;
    bit           saw_not_ready = 0;
    bit           stream_done = 0;

    task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic longint unsigned trunc(input longint unsigned x, input int sew);
        if (sew >= 64) return x;
        return x & ((64'd1 << sew) - 64'd1);
    endfunction

    function automatic longint sx(input longint unsigned x, input int sew);
        longint t;
        t = longint'(x << (64 - sew));
        return t >>> (64 - sew);
    endfunction

    function automatic longint unsigned opa(input beat_t b, input int i);
        if (b.us) return longint'($signed(b.rs));
        return b.v1[i*64 +: 64];
    endfunction

    // Reference model: one expected output beat per accepted beat that should produce one.
    function automatic void model_push(input beat_t b);
        exp_t e;
        int sew;
        longint unsigned a, x, c, r;
        bit is_red, cy;
        e = '{res: '0, m: '0, last: b.last, err: 1'b0};
        is_red = (b.op >= 3'd6);
        if (b.vsew > 3'd3 || (m_red && !is_red)) begin
            e.err = 1'b1;
            m_red = 0;
            exp_q.push_back(e);
            return;
        end
        sew = 8 << b.vsew;
        if (is_red) begin
            if (!m_red) m_acc = trunc(opa(b, 0), sew);
            for (int i = 0; i < 4; i++) begin
                if (b.vm || b.mask[i]) begin
                    x = b.v2[i*64 +: 64];
                    if (b.op == 3'd6) m_acc = trunc(m_acc + x, sew);
                    else if (sx(x, sew) > sx(m_acc, sew)) m_acc = trunc(x, sew);
                end
            end
            if (b.last) begin
                e.res[63:0] = m_acc;
                m_red = 0;
                exp_q.push_back(e);
            end else m_red = 1;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            a = trunc(opa(b, i), sew);
            x = trunc(b.v2[i*64 +: 64], sew);
            c = b.v3[i*64 +: 64];
            cy = 0;
            case (b.op)
                3'd0: r = x + a;
                3'd1: r = x - a;
                3'd2: r = a * x + c;
                3'd3: r = c - a * x;
                3'd4: begin
                    cy = (sew == 64) ? ((x + a) < x) : (((x + a) >> sew) & 64'd1) != 0;
                    r = cy;
                end
                default: begin
                    cy = x < a;
                    r = cy;
                end
            endcase
            if (!(b.vm || b.mask[i])) begin
                r = c;
                cy = 0;
            end
            e.res[i*64 +: 64] = trunc(r, sew);
            e.m[i] = cy;
        end
        exp_q.push_back(e);
    endfunction

    function automatic beat_t mk(input logic [2:0] op, input logic [2:0] sw, input logic v, input logic [3:0] mk_m,
                                 input logic [255:0] a, input logic [255:0] b, input logic [255:0] c, input logic l);
        beat_t t;
        t = '{op: op, vsew: sw, vm: v, mask: mk_m, us: 1'b0, rs: 32'd0, v1: a, v2: b, v3: c, last: l};
        return t;
    endfunction

    function automatic beat_t rand_beat();
        beat_t t;
        t.op   = 3'($urandom_range(0, 7));
        t.vsew = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        t.vm   = 1'($urandom_range(0, 1));
        t.mask = 4'($urandom_range(0, 15));
        t.us   = ($urandom_range(0, 3) == 0);
        t.rs   = $urandom;
        for (int i = 0; i < 8; i++) begin
            t.v1[i*32 +: 32] = $urandom;
            t.v2[i*32 +: 32] = $urandom;
            t.v3[i*32 +: 32] = $urandom;
        end
        t.last = (t.op >= 3'd6) ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
        return t;
    endfunction

    task automatic send_beat(input beat_t b);
        int n;
        opcode = b.op; vsew = b.vsew; vm = b.vm; mask = b.mask; use_scalar = b.us; rs = b.rs;
        vs1 = b.v1; vs2 = b.v2; vs3 = b.v3; in_last = b.last; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("accept_timeout", in_ready, 1'b1);
        model_push(b);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) stall_prev = 0;
        else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (!in_ready) saw_not_ready = 1;
            if (stall_prev) check("stall_stable", {out_result, out_mask, out_last, out_err}, stall_snap);
            if (out_valid && out_ready) begin
                out_count++;
                last_res = out_result; last_mask = out_mask; last_last = out_last;
                if (exp_q.size() == 0) check("extra_beat", out_valid, 1'b0);
                else begin
                    e = exp_q.pop_front();
                    check("result", out_result, e.res);
                    check("mask", out_mask, e.m);
                    check("last", out_last, e.last);
                    check("err", out_err, e.err);
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_snap = {out_result, out_mask, out_last, out_err};
        end
    end

    initial begin
        int cnt0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, '0);
        check("rst_out_mask", out_mask, '0);
        check("rst_out_last_err", {out_last, out_err}, 2'b00);
        rst_n = 1'b1;

        send_beat(mk(3'd0, 3'd0, 1'b1, 4'h0, {4{64'd1}}, {64'd3, 64'd2, 64'd1, 64'hFF}, '0, 1'b1));
        check("add_lat_s1", out_valid, 1'b0);
        @(posedge clk);
        #1 check("add_lat_s2", out_valid, 1'b1);
        drain();
        check("add_result", last_res, {64'd4, 64'd3, 64'd2, 64'd0});

        send_beat(mk(3'd1, 3'd2, 1'b0, 4'b0101, {4{64'd3}}, {4{64'd10}}, {4{64'd7}}, 1'b1));
        drain();
        check("sub_mask_vs3_7", last_res, {4{64'd7}});
        send_beat(mk(3'd1, 3'd2, 1'b0, 4'b0101, {4{64'd3}}, {4{64'd10}}, '0, 1'b1));
        drain();
        check("sub_mask_vs3_0", last_res, {64'd0, 64'd7, 64'd0, 64'd7});

        send_beat(mk(3'd4, 3'd1, 1'b1, 4'h0, {4{64'd1}}, {4{64'hFFFF}}, '0, 1'b1));
        drain();
        check("madc_mask", last_mask, 4'b1111);
        check("madc_result", last_res, {4{64'd1}});

        cnt0 = out_count;
        for (int k = 0; k < 3; k++)
            send_beat(mk(3'd6, 3'd3, 1'b1, 4'h0, {192'd0, 64'd100}, {64'd4, 64'd3, 64'd2, 64'd1}, '0, k == 2));
        drain();
        check("redsum_beats", out_count - cnt0, 1);
        check("redsum_value", last_res, {192'd0, 64'd130});
        check("redsum_last", last_last, 1'b1);

        saw_not_ready = 0;
        stream_done = 0;
        fork
            begin
                for (int k = 0; k < 10; k++) send_beat(mk(3'd0, 3'd3, 1'b1, 4'h0,
                    {4{64'(k)}}, {4{64'(100 * k)}}, '0, 1'b0));
                stream_done = 1;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_in_ready_low", saw_not_ready, 1'b1);

        stream_done = 0;
        fork
            begin
                for (int k = 0; k < 300; k++) send_beat(rand_beat());
                stream_done = 1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        send_beat(mk(3'd6, 3'd3, 1'b1, 4'h0, {192'd0, 64'd1000}, {4{64'd50}}, '0, 1'b0));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        m_red = 0;
        cnt0 = out_count;
        send_beat(mk(3'd7, 3'd3, 1'b1, 4'h0, {192'd0, -64'sd5},
                     {-64'sd8, -64'sd7, -64'sd2, -64'sd9}, '0, 1'b1));
        drain();
        check("redmax_beats", out_count - cnt0, 1);
        check("redmax_value", last_res, {192'd0, 64'hFFFF_FFFF_FFFF_FFFE});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
